// File: rtl/fifo_mem_ctrl_if.sv
// Push/pop/memory bundle for the FIFO controller.
// slave = controller side, master = requesters, reader and array.
interface fifo_mem_ctrl_if #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
);
    logic                req0_valid;
    logic [DATASIZE-1:0] req0_data;
    logic                req0_ready;
    logic                req1_valid;
    logic [DATASIZE-1:0] req1_data;
    logic                req1_ready;
    logic                rd_req;
    logic                rd_valid;
    logic [DATASIZE-1:0] rd_data;
    logic                mem_w_en;
    logic [ADDRSIZE-1:0] mem_waddr;
    logic [DATASIZE-1:0] mem_wdata;
    logic [ADDRSIZE-1:0] mem_raddr;
    logic [DATASIZE-1:0] mem_rdata;
    logic                full;
    logic                empty;
    logic [ADDRSIZE:0]   count;

    modport slave (
        input  req0_valid, req0_data,
        input  req1_valid, req1_data,
        input  rd_req, mem_rdata,
        output req0_ready, req1_ready,
        output rd_valid, rd_data,
        output mem_w_en, mem_waddr, mem_wdata, mem_raddr,
        output full, empty, count
    );

    modport master (
        output req0_valid, req0_data,
        output req1_valid, req1_data,
        output rd_req, mem_rdata,
        input  req0_ready, req1_ready,
        input  rd_valid, rd_data,
        input  mem_w_en, mem_waddr, mem_wdata, mem_raddr,
        input  full, empty, count
    );
endinterface

// File: rtl/fifo_mem_ctrl.sv
// Single-clock FIFO controller: round-robin push arbiter,
// pointer/status tracking and a registered pop stage.
module fifo_mem_ctrl #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input logic            wclk,
    input logic            wrst,
    fifo_mem_ctrl_if.slave bus
);
    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE:0]   rptr;
    logic                last_grant;
    logic                grant0;
    logic                grant1;
    logic                push;
    logic                pop;
    logic                full_w;
    logic                empty_w;
    logic                rd_valid_q;
    logic [DATASIZE-1:0] rd_data_q;

    assign empty_w = (wptr == rptr);
    assign full_w  = (wptr[ADDRSIZE] != rptr[ADDRSIZE]) &&
                     (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]);

    // Round-robin grant; last_grant=1 means requester 0 wins a tie.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!wrst && !full_w) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign push = grant0 || grant1;
    assign pop  = !wrst && bus.rd_req && !empty_w;

    // Pointer, arbitration history and read-data register.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wptr       <= '0;
            rptr       <= '0;
            last_grant <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (grant0) begin
                last_grant <= 1'b0;
            end else if (grant1) begin
                last_grant <= 1'b1;
            end
            rd_valid_q <= pop;
            if (pop) begin
                rd_data_q <= bus.mem_rdata;
                rptr      <= rptr + 1'b1;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.mem_w_en   = push;
    assign bus.mem_waddr  = wptr[ADDRSIZE-1:0];
    assign bus.mem_wdata  = grant1 ? bus.req1_data : bus.req0_data;
    assign bus.mem_raddr  = rptr[ADDRSIZE-1:0];
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.full       = full_w;
    assign bus.empty      = empty_w;
    assign bus.count      = wptr - rptr;
endmodule
